// File: rtl/div_pkg.sv
// Shared encodings for the M-extension divider controller.
// Latency: n/a (constants only).
// Backpressure: n/a.
package div_pkg;

  localparam int XLEN_DEF = 32;

  // Operation encoding: bit 0 set = unsigned, bit 1 set = remainder
  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  // Controller state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // True for the signed variants (DIV, REM)
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  // True when the remainder is the architectural result (REM, REMU)
  function automatic logic op_is_rem(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// Request/result bundle between the execute stage and the divider controller.
// Latency: n/a (wiring only).
// Backpressure: req_ready_o gates acceptance; results are strobed, never stalled.
interface div_ctrl_if #(
  parameter int XLEN = 32
);
  logic            req_valid_i;
  logic            req_ready_o;
  logic [1:0]      op_i;
  logic [XLEN-1:0] dividend_i;
  logic [XLEN-1:0] divisor_i;
  logic [4:0]      rd_i;
  logic            flush_i;
  logic            busy_o;
  logic            res_valid_o;
  logic [XLEN-1:0] res_o;
  logic [4:0]      res_rd_o;

  // Pipeline side drives requests and flush, observes results
  modport master (
    output req_valid_i, op_i, dividend_i, divisor_i, rd_i, flush_i,
    input  req_ready_o, busy_o, res_valid_o, res_o, res_rd_o
  );

  // Divider side
  modport slave (
    input  req_valid_i, op_i, dividend_i, divisor_i, rd_i, flush_i,
    output req_ready_o, busy_o, res_valid_o, res_o, res_rd_o
  );
endinterface

// File: rtl/div_core.sv
// Unsigned restoring division datapath, one quotient bit per step.
// Latency: XLEN steps after load; outputs are the live registers.
// Backpressure: none; the controller decides when to load and step.
module div_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  // Upper half is the running remainder, lower half holds the unconsumed
  // dividend bits which are progressively replaced by quotient bits.
  logic [2*XLEN-1:0] pr;
  logic [XLEN-1:0]   dvsr;
  logic [XLEN:0]     upper;
  logic [XLEN:0]     diff;

  // Remainder after shifting in the next dividend bit needs one extra bit
  assign upper = pr[2*XLEN-1:XLEN-1];
  assign diff  = upper - {1'b0, dvsr};

  assign quotient  = pr[XLEN-1:0];
  assign remainder = pr[2*XLEN-1:XLEN];

  // Load operands, or perform one shift/trial-subtract step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pr   <= '0;
      dvsr <= '0;
    end else if (load) begin
      pr   <= {{XLEN{1'b0}}, dividend};
      dvsr <= divisor;
    end else if (step) begin
      if (!diff[XLEN]) begin
        pr <= {diff[XLEN-1:0], pr[XLEN-2:0], 1'b1};
      end else begin
        pr <= {upper[XLEN-1:0], pr[XLEN-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/div_ctrl.sv
// Sequencer for DIV/DIVU/REM/REMU: special cases, sign handling, iteration, flush.
// Latency: 1 cycle for divide-by-zero/overflow, XLEN+2 cycles otherwise.
// Backpressure: accepts only in IDLE; busy_o stalls the pipeline while working.
module div_ctrl
  import div_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic       clk,
  input  logic       rst,
  div_ctrl_if.slave  bus
);

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [1:0]      op_q;
  logic [4:0]      rd_q;
  logic            neg_q;
  logic            neg_r;
  logic [XLEN-1:0] res_q;
  logic [4:0]      res_rd_q;

  logic            accept;
  logic            sgn;
  logic            div_zero;
  logic            sgn_ovf;
  logic            special;
  logic [XLEN-1:0] special_res;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            core_load;
  logic            core_step;
  logic [XLEN-1:0] core_q;
  logic [XLEN-1:0] core_r;
  logic [XLEN-1:0] fix_res;

  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = '1;

  assign bus.req_ready_o = (state == ST_IDLE) & ~rst;
  assign bus.busy_o      = (state != ST_IDLE);
  assign bus.res_valid_o = (state == ST_DONE) & ~bus.flush_i;
  assign bus.res_o       = res_q;
  assign bus.res_rd_o    = res_rd_q;

  assign accept = bus.req_valid_i & bus.req_ready_o & ~bus.flush_i;
  assign sgn    = op_is_signed(bus.op_i);

  // Classify the incoming request and form operand magnitudes
  always_comb begin
    div_zero    = (bus.divisor_i == '0);
    sgn_ovf     = sgn & (bus.dividend_i == MIN_NEG) & (bus.divisor_i == ALL_ONES);
    special     = div_zero | sgn_ovf;
    special_res = '0;
    if (div_zero) begin
      special_res = op_is_rem(bus.op_i) ? bus.dividend_i : ALL_ONES;
    end else if (sgn_ovf) begin
      special_res = op_is_rem(bus.op_i) ? '0 : bus.dividend_i;
    end
    a_mag = (sgn & bus.dividend_i[XLEN-1]) ? -bus.dividend_i : bus.dividend_i;
    b_mag = (sgn & bus.divisor_i[XLEN-1])  ? -bus.divisor_i  : bus.divisor_i;
  end

  assign core_load = accept & ~special;
  assign core_step = (state == ST_CALC) & ~bus.flush_i;

  div_core #(.XLEN(XLEN)) u_core (
    .clk       (clk),
    .rst       (rst),
    .load      (core_load),
    .step      (core_step),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .quotient  (core_q),
    .remainder (core_r)
  );

  // Select the architectural result and restore its sign
  always_comb begin
    if (op_is_rem(op_q)) begin
      fix_res = neg_r ? -core_r : core_r;
    end else begin
      fix_res = neg_q ? -core_q : core_q;
    end
  end

  // Next-state logic; flush abandons any in-flight work
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = special ? ST_DONE : ST_CALC;
      ST_CALC: begin
        if (bus.flush_i) state_nxt = ST_IDLE;
        else if (cnt == CNT_W'(XLEN-1)) state_nxt = ST_FIX;
      end
      ST_FIX:  state_nxt = bus.flush_i ? ST_IDLE : ST_DONE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register and iteration counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) cnt <= '0;
      else if (core_step) cnt <= cnt + 1'b1;
    end
  end

  // Capture request attributes at acceptance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q  <= '0;
      rd_q  <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      op_q  <= bus.op_i;
      rd_q  <= bus.rd_i;
      neg_q <= sgn & (bus.dividend_i[XLEN-1] ^ bus.divisor_i[XLEN-1]);
      neg_r <= sgn & bus.dividend_i[XLEN-1];
    end
  end

  // Result registers: special cases at accept, computed ones in FIX
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q    <= '0;
      res_rd_q <= '0;
    end else if (accept & special) begin
      res_q    <= special_res;
      res_rd_q <= bus.rd_i;
    end else if ((state == ST_FIX) & ~bus.flush_i) begin
      res_q    <= fix_res;
      res_rd_q <= rd_q;
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
module tb_div_ctrl;
  import div_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   strobes = 0;

  div_ctrl_if #(.XLEN(32)) bus();

  div_ctrl #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.res_valid_o) strobes++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request from IDLE and check result, destination, latency, busy
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input int exp_lat);
    int lat;
    int busy_cyc;
    chk({tag, "_rdy"}, 32'(bus.req_ready_o), 32'd1);
    bus.req_valid_i = 1'b1;
    bus.op_i        = op;
    bus.dividend_i  = a;
    bus.divisor_i   = b;
    bus.rd_i        = rd;
    tick();
    bus.req_valid_i = 1'b0;
    bus.dividend_i  = 32'hDEAD_BEEF;
    bus.divisor_i   = 32'h0000_0001;
    lat = 1;
    busy_cyc = 0;
    while (!bus.res_valid_o && lat < 100) begin
      if (bus.busy_o) busy_cyc++;
      tick();
      lat++;
    end
    if (bus.busy_o) busy_cyc++;
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_res"}, bus.res_o, exp);
    chk({tag, "_rd"},  32'(bus.res_rd_o), 32'(rd));
    chk({tag, "_busy"}, 32'(busy_cyc), 32'(exp_lat));
    tick();
    chk({tag, "_idle"}, {30'd0, bus.busy_o, bus.req_ready_o}, 32'd1);
    chk({tag, "_hold"}, bus.res_o, exp);
  endtask

  initial begin
    int s0;
    int s1_cyc;
    int s2_cyc;
    int acc_cyc;
    logic [31:0] s1_val;
    logic [31:0] s2_val;
    logic acc_flag;

    bus.req_valid_i = 1'b0;
    bus.op_i        = OP_DIV;
    bus.dividend_i  = '0;
    bus.divisor_i   = '0;
    bus.rd_i        = '0;
    bus.flush_i     = 1'b0;

    // Reset state
    tick();
    chk("rst_ready", 32'(bus.req_ready_o), 32'd0);
    chk("rst_busy",  32'(bus.busy_o), 32'd0);
    chk("rst_vld",   32'(bus.res_valid_o), 32'd0);
    chk("rst_res",   bus.res_o, 32'd0);
    chk("rst_rd",    32'(bus.res_rd_o), 32'd0);
    rst = 1'b0;
    tick();

    // Normal iterative cases
    run_op("div_neg",  OP_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 5'd5,  32'hFFFF_FFFD, 34);
    run_op("rem_neg",  OP_REM,  32'hFFFF_FFF9, 32'h0000_0002, 5'd6,  32'hFFFF_FFFF, 34);
    run_op("divu",     OP_DIVU, 32'd100,       32'd7,         5'd7,  32'd14,        34);
    run_op("remu",     OP_REMU, 32'd100,       32'd7,         5'd8,  32'd2,         34);
    run_op("rem_nd",   OP_REM,  32'h0000_0007, 32'hFFFF_FFFE, 5'd9,  32'd1,         34);
    run_op("divu_max", OP_DIVU, 32'hFFFF_FFFF, 32'd1,         5'd10, 32'hFFFF_FFFF, 34);

    // Special cases resolve in one cycle
    run_op("div_z",    OP_DIV,  32'd5,         32'd0,         5'd11, 32'hFFFF_FFFF, 1);
    run_op("remu_z",   OP_REMU, 32'd5,         32'd0,         5'd12, 32'd5,         1);
    run_op("div_ovf",  OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 1);
    run_op("rem_ovf",  OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0,         1);

    // Flush in CALC cycle 10
    s0 = strobes;
    bus.req_valid_i = 1'b1; bus.op_i = OP_DIVU; bus.dividend_i = 32'd9;
    bus.divisor_i = 32'd3; bus.rd_i = 5'd15;
    tick();
    bus.req_valid_i = 1'b0;
    repeat (9) tick();
    chk("fl_calc_busy", 32'(bus.busy_o), 32'd1);
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    chk("fl_calc_rdy", 32'(bus.req_ready_o), 32'd1);
    chk("fl_calc_res", bus.res_o, 32'd0);
    repeat (40) tick();
    chk("fl_calc_strb", 32'(strobes - s0), 32'd0);

    // Flush with request in IDLE: not accepted
    bus.req_valid_i = 1'b1; bus.flush_i = 1'b1;
    tick();
    bus.req_valid_i = 1'b0; bus.flush_i = 1'b0;
    chk("fl_idle_busy", 32'(bus.busy_o), 32'd0);

    run_op("divu_93", OP_DIVU, 32'd9, 32'd3, 5'd16, 32'd3, 34);

    // Flush in DONE suppresses the strobe
    s0 = strobes;
    bus.req_valid_i = 1'b1; bus.op_i = OP_DIVU; bus.dividend_i = 32'd30;
    bus.divisor_i = 32'd3; bus.rd_i = 5'd17;
    tick();
    bus.req_valid_i = 1'b0;
    repeat (33) tick();
    bus.flush_i = 1'b1;
    #1;
    chk("fl_done_busy", 32'(bus.busy_o), 32'd1);
    chk("fl_done_vld", 32'(bus.res_valid_o), 32'd0);
    tick();
    bus.flush_i = 1'b0;
    chk("fl_done_strb", 32'(strobes - s0), 32'd0);
    chk("fl_done_rdy", 32'(bus.req_ready_o), 32'd1);

    // Asynchronous reset mid-CALC
    bus.req_valid_i = 1'b1; bus.op_i = OP_DIV; bus.dividend_i = 32'd1000;
    bus.divisor_i = 32'd3; bus.rd_i = 5'd18;
    tick();
    bus.req_valid_i = 1'b0;
    repeat (5) tick();
    #2;
    rst = 1'b1;
    #1;
    chk("ar_busy", 32'(bus.busy_o), 32'd0);
    chk("ar_vld",  32'(bus.res_valid_o), 32'd0);
    chk("ar_res",  bus.res_o, 32'd0);
    chk("ar_rdy",  32'(bus.req_ready_o), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    run_op("div_204", OP_DIV, 32'd20, 32'd4, 5'd19, 32'd5, 34);

    // Back-to-back with req_valid held
    bus.req_valid_i = 1'b1; bus.op_i = OP_DIVU; bus.dividend_i = 32'd50;
    bus.divisor_i = 32'd5; bus.rd_i = 5'd20;
    tick();
    bus.op_i = OP_REMU; bus.divisor_i = 32'd6; bus.rd_i = 5'd21;
    s1_cyc = 0; s2_cyc = 0; acc_cyc = 0; acc_flag = 1'b0;
    s1_val = '0; s2_val = '0;
    for (int c = 1; c < 120 && s2_cyc == 0; c++) begin
      if (acc_flag) bus.req_valid_i = 1'b0;
      if (bus.res_valid_o) begin
        if (s1_cyc == 0) begin s1_cyc = c; s1_val = bus.res_o; end
        else begin s2_cyc = c; s2_val = bus.res_o; end
      end
      if (bus.req_ready_o && bus.req_valid_i && !acc_flag) begin
        acc_cyc = c; acc_flag = 1'b1;
      end
      tick();
    end
    bus.req_valid_i = 1'b0;
    chk("b2b_s1_cyc", 32'(s1_cyc), 32'd34);
    chk("b2b_s1_val", s1_val, 32'd10);
    chk("b2b_acc",    32'(acc_cyc), 32'd35);
    chk("b2b_gap",    32'(s2_cyc - s1_cyc), 32'd35);
    chk("b2b_s2_val", s2_val, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
